// File: rtl/qgemm_clock_pkg.sv
// rtl/qgemm_clock_pkg.sv - shared constants and helpers for the clock divider/reset sequencer
package qgemm_clock_pkg;

    localparam int DEF_LOCK_CYCLES = 16;
    localparam int DEF_RST_STAGES  = 2;

    // Channel-select width: at least one bit even for a single channel.
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/qgemm_clock_divgen_ch.sv
// rtl/qgemm_clock_divgen_ch.sv - one divided-clock channel with glitch-free re-division and reset release
//
// Ports:
//   clk, rstnn     reference clock, asynchronous active-low reset
//   locked         lock indicator from the top level
//   relock         soft relock pulse (highest priority)
//   cfg_wr         accepted config write for this channel
//   cfg_div        divisor carried by the write
//   clk_div        registered divided clock (period 2*div)
//   tick           half-period strobe, combinational from registers
//   rstnn_ch       channel reset, released after RST_STAGES ticks
//   pending        a divisor change is waiting for the period end
//   div            active divisor
module qgemm_clock_divgen_ch
    import qgemm_clock_pkg::*;
#(
    parameter int DIV_W      = 8,
    parameter int RESET_DIV  = 1,
    parameter int RST_STAGES = DEF_RST_STAGES
) (
    input  logic             clk,
    input  logic             rstnn,
    input  logic             locked,
    input  logic             relock,
    input  logic             cfg_wr,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             clk_div,
    output logic             tick,
    output logic             rstnn_ch,
    output logic             pending,
    output logic [DIV_W-1:0] div
);

    localparam int REL_W = $clog2(RST_STAGES + 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RST_STAGES - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pending_q, pending_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clk_div_q, clk_div_d;
    logic [REL_W-1:0] rel_cnt_q, rel_cnt_d;
    logic             rstnn_ch_q, rstnn_ch_d;

    logic running;
    logic tick_w;
    logic stopped;

    assign running = locked && (div_q != '0);
    assign tick_w  = running && (cnt_q == div_q - DIV_W'(1));
    // Safe to change the divisor right away: nothing is running, or we are
    // at the very first cycle of a low phase.
    assign stopped = !locked || (div_q == '0) || (!clk_div_q && (cnt_q == '0));

    always_comb begin
        div_d      = div_q;
        pend_div_d = pend_div_q;
        pending_d  = pending_q;
        cnt_d      = cnt_q;
        clk_div_d  = clk_div_q;
        rel_cnt_d  = rel_cnt_q;
        rstnn_ch_d = rstnn_ch_q;

        if (relock) begin
            cnt_d      = '0;
            clk_div_d  = 1'b0;
            rel_cnt_d  = '0;
            rstnn_ch_d = 1'b0;
            pending_d  = 1'b0;
            if (cfg_wr) begin
                div_d = cfg_div;
            end else if (pending_q) begin
                div_d = pend_div_q;
            end
        end else begin
            if (running) begin
                if (tick_w) begin
                    cnt_d = '0;
                    // A pending divisor only lands at the end of a high phase,
                    // so neither phase is ever shortened.
                    if (clk_div_q && pending_q) begin
                        clk_div_d = 1'b0;
                        div_d     = pend_div_q;
                        pending_d = 1'b0;
                    end else begin
                        clk_div_d = !clk_div_q;
                    end
                    if (!rstnn_ch_q) begin
                        if (rel_cnt_q == REL_LAST) begin
                            rstnn_ch_d = 1'b1;
                        end else begin
                            rel_cnt_d = rel_cnt_q + REL_W'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end else if (div_q == '0) begin
                cnt_d     = '0;
                clk_div_d = 1'b0;
            end

            if (cfg_wr) begin
                if (stopped) begin
                    div_d = cfg_div;
                end else begin
                    pend_div_d = cfg_div;
                    pending_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            div_q      <= DIV_W'(RESET_DIV);
            pend_div_q <= '0;
            pending_q  <= 1'b0;
            cnt_q      <= '0;
            clk_div_q  <= 1'b0;
            rel_cnt_q  <= '0;
            rstnn_ch_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            clk_div_q  <= clk_div_d;
            rel_cnt_q  <= rel_cnt_d;
            rstnn_ch_q <= rstnn_ch_d;
        end
    end

    assign clk_div  = clk_div_q;
    assign tick     = tick_w;
    assign rstnn_ch = rstnn_ch_q;
    assign pending  = pending_q;
    assign div      = div_q;

endmodule

// File: rtl/qgemm_clock_divgen.sv
// rtl/qgemm_clock_divgen.sv - multi-channel clock divider with lock model and reset sequencer
//
// Ports:
//   clk, rstnn     reference clock, asynchronous active-low reset
//   soft_relock    pulse restarting the lock sequence
//   cfg_valid/ready, cfg_ch, cfg_div   runtime divisor update handshake
//   locked         lock indicator
//   clk_div        divided clocks, one per channel
//   clk_tick       half-period strobes
//   rstnn_ch       per-channel active-low resets
//   cur_div        active divisors, flat, channel 0 in the LSBs
module qgemm_clock_divgen
    import qgemm_clock_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 8,
    parameter int RESET_DIV   = 1,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int RST_STAGES  = DEF_RST_STAGES,
    localparam int CH_W       = ch_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rstnn,
    input  logic                    soft_relock,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [DIV_W-1:0]        cfg_div,
    output logic                    locked,
    output logic [NUM_CH-1:0]       clk_div,
    output logic [NUM_CH-1:0]       clk_tick,
    output logic [NUM_CH-1:0]       rstnn_ch,
    output logic [NUM_CH*DIV_W-1:0] cur_div
);

    localparam int LC_W = $clog2(LOCK_CYCLES);
    localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCK_CYCLES - 1);

    logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] ch_wr;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (soft_relock) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else if (!locked_q) begin
            if (lock_cnt_q == LOCK_LAST) begin
                locked_d = 1'b1;
            end else begin
                lock_cnt_d = lock_cnt_q + LC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    // Out-of-range channel selects are always accepted and then dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_wr[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        qgemm_clock_divgen_ch #(
            .DIV_W      (DIV_W),
            .RESET_DIV  (RESET_DIV),
            .RST_STAGES (RST_STAGES)
        ) u_ch (
            .clk      (clk),
            .rstnn    (rstnn),
            .locked   (locked_q),
            .relock   (soft_relock),
            .cfg_wr   (ch_wr[g]),
            .cfg_div  (cfg_div),
            .clk_div  (clk_div[g]),
            .tick     (clk_tick[g]),
            .rstnn_ch (rstnn_ch[g]),
            .pending  (pending[g]),
            .div      (cur_div[g*DIV_W +: DIV_W])
        );
    end

    assign locked = locked_q;

endmodule

// File: tb/tb_qgemm_clock_divgen.sv
// tb/tb_qgemm_clock_divgen.sv - directed self-checking bench for qgemm_clock_divgen
module tb_qgemm_clock_divgen;

    logic        clk = 1'b0;
    logic        rstnn = 1'b0;
    logic        soft_relock = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = 2'd0;
    logic [7:0]  cfg_div = 8'd0;
    logic        locked;
    logic [2:0]  clk_div;
    logic [2:0]  clk_tick;
    logic [2:0]  rstnn_ch;
    logic [23:0] cur_div;

    int vectors = 0;
    int fails   = 0;
    int n       = 0;

    typedef struct {
        int         n;
        logic       lk;
        logic [2:0] cd;
        logic [2:0] tk;
        logic [2:0] rs;
    } vec_t;

    vec_t rows[$];

    qgemm_clock_divgen #(
        .NUM_CH      (3),
        .DIV_W       (8),
        .RESET_DIV   (2),
        .LOCK_CYCLES (16),
        .RST_STAGES  (2)
    ) dut (
        .clk         (clk),
        .rstnn       (rstnn),
        .soft_relock (soft_relock),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .locked      (locked),
        .clk_div     (clk_div),
        .clk_tick    (clk_tick),
        .rstnn_ch    (rstnn_ch),
        .cur_div     (cur_div)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at n=%0d: got %0h expected %0h", nm, n, act, exp);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            while (n < rows[i].n) step();
            chk($sformatf("row%0d locked", i), 32'(locked), 32'(rows[i].lk));
            chk($sformatf("row%0d clk_div", i), 32'(clk_div), 32'(rows[i].cd));
            chk($sformatf("row%0d clk_tick", i), 32'(clk_tick), 32'(rows[i].tk));
            chk($sformatf("row%0d rstnn_ch", i), 32'(rstnn_ch), 32'(rows[i].rs));
        end
    endtask

    task automatic ready_for(input logic [1:0] ch, input logic exp, input string nm);
        cfg_ch = ch;
        #1;
        chk(nm, 32'(cfg_ready), 32'(exp));
    endtask

    initial begin
        // n counts edges since reset release; c = n-16 is the cycle since lock.
        rows.push_back('{15, 1'b0, 3'b000, 3'b000, 3'b000});
        rows.push_back('{16, 1'b1, 3'b000, 3'b000, 3'b000});
        rows.push_back('{17, 1'b1, 3'b000, 3'b111, 3'b000});
        rows.push_back('{18, 1'b1, 3'b111, 3'b000, 3'b000});
        rows.push_back('{19, 1'b1, 3'b111, 3'b111, 3'b000});
        rows.push_back('{20, 1'b1, 3'b000, 3'b000, 3'b111});
        rows.push_back('{21, 1'b1, 3'b000, 3'b111, 3'b111});
        rows.push_back('{22, 1'b1, 3'b111, 3'b000, 3'b111});
        // after ch1 is re-divided to 5 (runs from c=8)
        rows.push_back('{28, 1'b1, 3'b000, 3'b010, 3'b111});
        rows.push_back('{29, 1'b1, 3'b010, 3'b101, 3'b111});
        rows.push_back('{33, 1'b1, 3'b010, 3'b111, 3'b111});
        rows.push_back('{34, 1'b1, 3'b101, 3'b000, 3'b111});

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst locked", 32'(locked), 32'd0);
        chk("rst clk_div", 32'(clk_div), 32'd0);
        chk("rst clk_tick", 32'(clk_tick), 32'd0);
        chk("rst rstnn_ch", 32'(rstnn_ch), 32'd0);
        chk("rst cur_div", 32'(cur_div), 32'h020202);
        rstnn = 1'b1;
        n = 0;

        // 1: lock and default division
        run_rows(0, 7);
        chk("t1 cur_div", 32'(cur_div), 32'h020202);

        // 2: re-divide ch1 to 5 in the middle of its high phase (c=6)
        cfg_ch = 2'd1; cfg_div = 8'd5; cfg_valid = 1'b1;
        #1;
        chk("t2 ready before", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        ready_for(2'd1, 1'b0, "t2 ready ch1 pending");
        ready_for(2'd0, 1'b1, "t2 ready ch0");
        ready_for(2'd2, 1'b1, "t2 ready ch2");
        chk("t2 cur_div held", 32'(cur_div), 32'h020202);
        chk("t2 clk_div c7", 32'(clk_div), 32'b111);
        step();
        chk("t2 cur_div applied", 32'(cur_div), 32'h020502);
        ready_for(2'd1, 1'b1, "t2 ready ch1 freed");
        chk("t2 clk_div c8", 32'(clk_div), 32'b000);
        run_rows(8, 11);

        // 3: stop ch2 via pending, then restart it directly (c=18)
        cfg_ch = 2'd2; cfg_div = 8'd0; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        chk("t3 ch2 div 0", 32'(cur_div[23:16]), 32'd0);
        chk("t3 ch2 clk low", 32'(clk_div[2]), 32'd0);
        step();
        chk("t3 ch2 no tick", 32'(clk_tick[2]), 32'd0);
        chk("t3 ch0 tick", 32'(clk_tick[0]), 32'd1);
        step();
        chk("t3 ch2 clk still low", 32'(clk_div[2]), 32'd0);
        chk("t3 ch0 clk", 32'(clk_div[0]), 32'd1);
        chk("t3 rstnn_ch kept", 32'(rstnn_ch), 32'b111);
        cfg_ch = 2'd2; cfg_div = 8'd3; cfg_valid = 1'b1;
        #1;
        chk("t3 ready ch2", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        chk("t3 ch2 div 3", 32'(cur_div[23:16]), 32'd3);
        chk("t3 ch2 tick cyc0", 32'(clk_tick[2]), 32'd0);
        step();
        chk("t3 ch2 tick cyc1", 32'(clk_tick[2]), 32'd0);
        step();
        chk("t3 ch2 tick cyc2", 32'(clk_tick[2]), 32'd1);
        chk("t3 ch2 clk cyc2", 32'(clk_div[2]), 32'd0);
        step();
        chk("t3 ch2 clk cyc3", 32'(clk_div[2]), 32'd1);
        steps(2);
        chk("t3 ch2 tick cyc5", 32'(clk_tick[2]), 32'd1);
        chk("t3 ch2 clk cyc5", 32'(clk_div[2]), 32'd1);
        step();
        chk("t3 ch2 clk cyc6", 32'(clk_div[2]), 32'd0);

        // 4: soft relock with a simultaneous ch0 write
        soft_relock = 1'b1;
        cfg_ch = 2'd0; cfg_div = 8'd7; cfg_valid = 1'b1;
        #1;
        chk("t4 ready ch0", 32'(cfg_ready), 32'd1);
        step();
        soft_relock = 1'b0;
        cfg_valid = 1'b0;
        n = 0;
        chk("t4 locked drop", 32'(locked), 32'd0);
        chk("t4 clk_div", 32'(clk_div), 32'd0);
        chk("t4 rstnn_ch", 32'(rstnn_ch), 32'd0);
        chk("t4 clk_tick", 32'(clk_tick), 32'd0);
        chk("t4 cur_div", 32'(cur_div), 32'h030507);
        steps(15);
        chk("t4 locked r15", 32'(locked), 32'd0);
        step();
        chk("t4 locked r16", 32'(locked), 32'd1);
        chk("t4 clk_div r16", 32'(clk_div), 32'd0);
        steps(5);
        chk("t4 ch0 tick r21", 32'(clk_tick[0]), 32'd0);
        step();
        chk("t4 ch0 tick r22", 32'(clk_tick[0]), 32'd1);
        chk("t4 ch0 clk r22", 32'(clk_div[0]), 32'd0);
        chk("t4 rstnn_ch r22", 32'(rstnn_ch), 32'b100);
        step();
        chk("t4 ch0 clk r23", 32'(clk_div[0]), 32'd1);
        steps(6);
        chk("t4 ch0 tick r29", 32'(clk_tick[0]), 32'd1);
        chk("t4 ch0 clk r29", 32'(clk_div[0]), 32'd1);
        step();
        chk("t4 ch0 clk r30", 32'(clk_div[0]), 32'd0);
        chk("t4 rstnn_ch r30", 32'(rstnn_ch), 32'b111);

        // 5: out-of-range channel is accepted and dropped
        cfg_ch = 2'd3; cfg_div = 8'd9; cfg_valid = 1'b1;
        #1;
        chk("t5 ready oor", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        chk("t5 cur_div", 32'(cur_div), 32'h030507);
        ready_for(2'd0, 1'b1, "t5 ready ch0");
        ready_for(2'd1, 1'b1, "t5 ready ch1");

        // 6: async reset while ch0 has a pending update (ch0 at cnt=1)
        cfg_ch = 2'd0; cfg_div = 8'd4; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        ready_for(2'd0, 1'b0, "t6 ready ch0 pending");
        chk("t6 ch0 div held", 32'(cur_div[7:0]), 32'd7);
        #1;
        rstnn = 1'b0;
        #1;
        chk("t6 locked", 32'(locked), 32'd0);
        chk("t6 clk_div", 32'(clk_div), 32'd0);
        chk("t6 clk_tick", 32'(clk_tick), 32'd0);
        chk("t6 rstnn_ch", 32'(rstnn_ch), 32'd0);
        chk("t6 cur_div", 32'(cur_div), 32'h020202);
        chk("t6 ready cleared", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rstnn = 1'b1;
        n = 0;
        steps(16);
        chk("t6 relocked", 32'(locked), 32'd1);
        chk("t6 cur_div after", 32'(cur_div), 32'h020202);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
